ft_restore: RTL and testbench

Checkpoint restore engine for the fault-tolerant core wrapper. On a start pulse it acts as the initiator on the checkpoint memory's data port (req/gnt/rvalid) and reads back the saved register file words and the saved PC. It replays each register word into the core register file write port and then presents the PC for loading. It sits between the checkpoint memory and the core during rollback recovery.

---
 rtl/ft_restore.sv | 139 +++++++++++++
 tb/tb_ft_restore.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_restore.sv
// ft_restore: checkpoint restore engine for the fault-tolerant core wrapper.
//
// On a start pulse it reads the saved register file words 1..NUM_REGS-1 and
// then the saved PC from checkpoint memory. Only one read is outstanding at a
// time. Each register word is replayed into the core register file write
// port, and the PC is presented for loading at the end.
//
// Handshake: data_req_o is held high with a stable data_addr_o until a cycle
// in which data_gnt_i is also high (the grant may come in the request cycle).
// Read data arrives later as a single data_rvalid_i cycle, with data_err_i
// qualified by it. The engine only accepts rvalid while it waits for the
// granted read's data.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  restore request, sampled only when idle
//   busy_o, done_o, error_o  status (done is a one-cycle pulse, error sticky)
//   rf_we_o/rf_addr_o/rf_data_o  register file write port
//   pc_load_o/pc_o           restored PC and its load strobe
//   data_*                   checkpoint memory read port (initiator side)
//   state_o                  current FSM state, for observation
module ft_restore #(
  parameter int NUM_REGS = 32,
  parameter int PC_WORD  = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_addr_o,
  output logic [31:0] rf_data_o,
  output logic        pc_load_o,
  output logic [31:0] pc_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic [31:0] data_addr_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [5:0] IDX_PC   = 6'(PC_WORD);
  localparam logic [5:0] IDX_LAST = 6'(NUM_REGS - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] idx;
  logic       accept;
  logic       word_ok;
  logic       word_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    word_ok    = 1'b0;
    word_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (data_gnt_i) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (data_rvalid_i) begin
          if (data_err_i) begin
            word_err   = 1'b1;
            state_next = S_FINISH;
          end else begin
            word_ok    = 1'b1;
            state_next = (idx < IDX_PC) ? S_REQ : S_FINISH;
          end
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Status and request are decoded straight from the state so that an
  // asynchronous reset drops data_req_o immediately.
  assign busy_o      = (state == S_REQ) || (state == S_WAIT);
  assign done_o      = (state == S_FINISH);
  assign data_req_o  = (state == S_REQ);
  assign data_addr_o = {24'd0, idx, 2'b00};
  assign state_o     = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx       <= 6'd0;
      error_o   <= 1'b0;
      rf_we_o   <= 1'b0;
      rf_addr_o <= 5'd0;
      rf_data_o <= 32'd0;
      pc_load_o <= 1'b0;
      pc_o      <= 32'd0;
    end else begin
      rf_we_o   <= 1'b0;
      pc_load_o <= 1'b0;
      if (accept) begin
        idx     <= 6'd1;
        error_o <= 1'b0;
      end
      if (word_err) error_o <= 1'b1;
      if (word_ok) begin
        if (idx < IDX_PC) begin
          rf_we_o   <= 1'b1;
          rf_addr_o <= idx[4:0];
          rf_data_o <= data_rdata_i;
          // After the last architectural register jump straight to the PC word.
          idx       <= (idx == IDX_LAST) ? IDX_PC : idx + 6'd1;
        end else begin
          pc_o      <= data_rdata_i;
          pc_load_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ft_restore.sv
// Testbench for ft_restore: a checkpoint memory responder with configurable
// grant delay and per-word error injection, an rf-write scoreboard and a
// table of restore scenarios, plus a hand-written reset-in-WAIT sequence.
module tb_ft_restore;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic        gnt, rvalid, merr;
  logic [31:0] rdata;

  logic        a_busy, a_done, a_error, a_rf_we, a_pc_load, a_req;
  logic [4:0]  a_rf_addr;
  logic [31:0] a_rf_data, a_pc, a_addr;
  logic [1:0]  a_state;
  logic        b_busy, b_done, b_error, b_rf_we, b_pc_load, b_req;
  logic [4:0]  b_rf_addr;
  logic [31:0] b_rf_data, b_pc, b_addr;
  logic [1:0]  b_state;

  ft_restore dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
    .busy_o(a_busy), .done_o(a_done), .error_o(a_error),
    .rf_we_o(a_rf_we), .rf_addr_o(a_rf_addr), .rf_data_o(a_rf_data),
    .pc_load_o(a_pc_load), .pc_o(a_pc),
    .data_req_o(a_req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .data_addr_o(a_addr), .data_rdata_i(rdata), .data_err_i(merr),
    .state_o(a_state)
  );

  ft_restore #(.NUM_REGS(16), .PC_WORD(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
    .busy_o(b_busy), .done_o(b_done), .error_o(b_error),
    .rf_we_o(b_rf_we), .rf_addr_o(b_rf_addr), .rf_data_o(b_rf_data),
    .pc_load_o(b_pc_load), .pc_o(b_pc),
    .data_req_o(b_req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .data_addr_o(b_addr), .data_rdata_i(rdata), .data_err_i(merr),
    .state_o(b_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- selected-DUT view ----------------
  logic        sel;
  logic        m_busy, m_done, m_error, m_rf_we, m_pc_load, m_req;
  logic [4:0]  m_rf_addr;
  logic [31:0] m_rf_data, m_pc, m_addr;

  always_comb begin
    m_busy    = sel ? b_busy    : a_busy;
    m_done    = sel ? b_done    : a_done;
    m_error   = sel ? b_error   : a_error;
    m_rf_we   = sel ? b_rf_we   : a_rf_we;
    m_rf_addr = sel ? b_rf_addr : a_rf_addr;
    m_rf_data = sel ? b_rf_data : a_rf_data;
    m_pc_load = sel ? b_pc_load : a_pc_load;
    m_pc      = sel ? b_pc      : a_pc;
    m_req     = sel ? b_req     : a_req;
    m_addr    = sel ? b_addr    : a_addr;
  end

  // ---------------- bookkeeping ----------------
  int tests  = 0;
  int failed = 0;

  logic [36:0] exp_q[$];   // {rf_addr, rf_data}
  logic [31:0] addr_q[$];  // expected granted addresses, in order

  int cfg_gdelay   = 0;
  int cfg_err_word = 0;
  bit cfg_spur     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int i);
    if (i == 32) return 32'h0000_0400;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // ---------------- checkpoint memory responder ----------------
  // Inputs change on the falling edge; the DUT samples them on the rising edge.
  initial begin
    bit          pending;
    int          wcnt;
    int          p_idx;
    logic [31:0] held;
    logic [31:0] ea;
    pending = 1'b0; wcnt = 0; p_idx = 0; held = '0;
    gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0; merr = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        wcnt    = 0;
        continue;
      end
      if (pending) begin
        pending = 1'b0;
        rvalid  = 1'b1;
        if (p_idx == cfg_err_word) begin
          merr  = 1'b1;
          rdata = 32'hBAD0_0000 | 32'(p_idx);
        end else begin
          rdata = mem_word(p_idx);
        end
      end else if (m_req) begin
        if (wcnt > 0) check("addr_hold", m_addr, held);
        else          held = m_addr;
        if (cfg_spur) begin
          rvalid = 1'b1;
          merr   = 1'b1;
          rdata  = 32'hDEAD_BEEF;
        end
        if (wcnt >= cfg_gdelay) begin
          gnt     = 1'b1;
          wcnt    = 0;
          pending = 1'b1;
          p_idx   = int'(m_addr[7:2]);
          if (addr_q.size() == 0) begin
            check("unexpected_read_addr", m_addr, 32'hFFFF_FFFF);
          end else begin
            ea = addr_q.pop_front();
            check("read_addr", m_addr, ea);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- rf write scoreboard ----------------
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && m_rf_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rf_write_addr", 32'(m_rf_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rf_addr", 32'(m_rf_addr), 32'(e[36:32]));
          check("rf_data", m_rf_data, e[31:0]);
        end
      end
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    int          gdelay;
    int          err_word;    // 0 = no error
    bit          spur;
    bit          start_busy;
    bit          use_b;       // NUM_REGS=16 instance
    int          exp_cyc;     // cycle of done_o, start accepted at edge 0
    bit          exp_err;
    bit          exp_pcl;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  task automatic set_start(input bit v);
    start_a = v && !sel;
    start_b = v && sel;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int nregs;
    int done_cyc;
    sel          = v.use_b;
    cfg_gdelay   = v.gdelay;
    cfg_err_word = v.err_word;
    cfg_spur     = v.spur;
    exp_q.delete();
    addr_q.delete();
    nregs = v.use_b ? 16 : 32;
    for (int r = 1; r < nregs; r++) begin
      if (v.err_word == 0 || r < v.err_word)
        exp_q.push_back({5'(r), mem_word(r)});
      if (v.err_word == 0 || r <= v.err_word)
        addr_q.push_back(32'(r) << 2);
    end
    if (v.err_word == 0 || v.err_word == 32) addr_q.push_back(32'h80);

    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    check($sformatf("v%0d_busy_c1", n), 32'(m_busy), 32'd1);
    check($sformatf("v%0d_error_clear_c1", n), 32'(m_error), 32'd0);

    done_cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      set_start(v.start_busy && c == 6);
      if (m_done) begin
        done_cyc = c;
        break;
      end
    end
    set_start(1'b0);
    check($sformatf("v%0d_done_cycle", n), 32'(done_cyc), 32'(v.exp_cyc));
    check($sformatf("v%0d_pc_load", n), 32'(m_pc_load), 32'(v.exp_pcl));
    check($sformatf("v%0d_pc", n), m_pc, v.exp_pc);
    check($sformatf("v%0d_error", n), 32'(m_error), 32'(v.exp_err));
    check($sformatf("v%0d_busy_done", n), 32'(m_busy), 32'd0);
    #1;
    check($sformatf("v%0d_rf_left", n), 32'(exp_q.size()), 32'd0);
    check($sformatf("v%0d_reads_left", n), 32'(addr_q.size()), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", n), 32'(m_done), 32'd0);
    check($sformatf("v%0d_pc_load_pulse", n), 32'(m_pc_load), 32'd0);
    check($sformatf("v%0d_error_sticky", n), 32'(m_error), 32'(v.exp_err));
    cfg_spur = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    32'(m_busy),    32'd0);
    check({tag, "_done"},    32'(m_done),    32'd0);
    check({tag, "_error"},   32'(m_error),   32'd0);
    check({tag, "_rf_we"},   32'(m_rf_we),   32'd0);
    check({tag, "_rf_addr"}, 32'(m_rf_addr), 32'd0);
    check({tag, "_rf_data"}, m_rf_data,      32'd0);
    check({tag, "_pc_load"}, 32'(m_pc_load), 32'd0);
    check({tag, "_pc"},      m_pc,           32'd0);
    check({tag, "_req"},     32'(m_req),     32'd0);
    check({tag, "_addr"},    m_addr,         32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failed++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int found;
    vecs[0] = '{0, 0,  1'b0, 1'b0, 1'b0,  65, 1'b0, 1'b1, 32'h400};
    vecs[1] = '{3, 0,  1'b0, 1'b0, 1'b0, 161, 1'b0, 1'b1, 32'h400};
    vecs[2] = '{0, 10, 1'b0, 1'b0, 1'b0,  21, 1'b1, 1'b0, 32'h400};
    vecs[3] = '{0, 0,  1'b0, 1'b0, 1'b0,  65, 1'b0, 1'b1, 32'h400};
    vecs[4] = '{0, 0,  1'b1, 1'b1, 1'b0,  65, 1'b0, 1'b1, 32'h400};
    vecs[5] = '{0, 0,  1'b0, 1'b0, 1'b1,  33, 1'b0, 1'b1, 32'h400};
    vecs[6] = '{1, 32, 1'b0, 1'b0, 1'b0,  97, 1'b1, 1'b0, 32'h400};

    sel = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_a");
    sel = 1'b1;
    check_zero("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset while waiting for register 5's data.
    sel = 1'b0;
    cfg_gdelay = 0; cfg_err_word = 0; cfg_spur = 1'b0;
    exp_q.delete();
    addr_q.delete();
    for (int r = 1; r <= 5; r++) begin
      if (r < 5) exp_q.push_back({5'(r), mem_word(r)});
      addr_q.push_back(32'(r) << 2);
    end
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (m_busy && !m_req && m_addr == 32'h14) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reached_wait_reg5", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_zero("rst_async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("rst_rf_left", 32'(exp_q.size()), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_done", 32'(m_done), 32'd0);
      check("rst_idle", 32'(m_busy), 32'd0);
    end
    run_vec(7, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
